// File: rtl/ccip_mmio_csr.sv
// ccip_mmio_csr: CCI-P MMIO CSR block. Decodes c0 MMIO reads/writes, holds the
// AFU DFH/ID and the job-control register file, and returns c2 read responses
// one cycle after each request.
module ccip_mmio_csr #(
  parameter logic [127:0] AFU_ID = 128'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_rd_valid,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_addr,
  input  logic [1:0]  mmio_len,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wdata,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        ctrl_start,
  output logic [63:0] ctrl_src_addr,
  output logic [63:0] ctrl_dst_addr,
  output logic [31:0] ctrl_len,
  input  logic        stat_busy,
  input  logic        stat_done
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TID_W  = 9;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned HALF_W = 32;

  localparam logic [ADDR_W-1:0] A_DFH      = 16'h0000;
  localparam logic [ADDR_W-1:0] A_ID_L     = 16'h0002;
  localparam logic [ADDR_W-1:0] A_ID_H     = 16'h0004;
  localparam logic [ADDR_W-1:0] A_SCRATCH  = 16'h0020;
  localparam logic [ADDR_W-1:0] A_SRC_ADDR = 16'h0022;
  localparam logic [ADDR_W-1:0] A_DST_ADDR = 16'h0024;
  localparam logic [ADDR_W-1:0] A_LENGTH   = 16'h0026;
  localparam logic [ADDR_W-1:0] A_CONTROL  = 16'h0028;
  localparam logic [ADDR_W-1:0] A_STATUS   = 16'h002A;
  localparam logic [ADDR_W-1:0] A_CYCLES   = 16'h002C;

  // Device feature header: AFU type, end-of-list set, no next DFH.
  localparam logic [DATA_W-1:0] DFH_VAL =
    {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              start_q, start_d;
  logic              done_sticky_q, done_sticky_d;
  logic              start_err_q, start_err_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
  logic [DATA_W-1:0] cycles_q, cycles_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [TID_W-1:0]  rsp_tid_q, rsp_tid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [ADDR_W-1:0] reg_addr_c;
  logic              is4_c;
  logic              hi_c;
  logic [DATA_W-1:0] rd_reg_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              start_req_c;
  logic              clear_req_c;
  logic [CNT_W-1:0]  cnt_base_c;

  // Merge a write into an 8 B register, honouring 4 B half selection.
  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] wd,
    input logic              is4,
    input logic              hi
  );
    logic [DATA_W-1:0] r;
    r = wd;
    if (is4) begin
      if (hi) r = {wd[HALF_W-1:0], old_v[HALF_W-1:0]};
      else    r = {old_v[DATA_W-1:HALF_W], wd[HALF_W-1:0]};
    end
    return r;
  endfunction

  // Address decode shared by the read and write paths.
  always_comb begin
    reg_addr_c = {mmio_addr[ADDR_W-1:1], 1'b0};
    is4_c      = (mmio_len == 2'd0);
    hi_c       = is4_c & mmio_addr[0];
  end

  // Read mux: current register contents, so a same-cycle write is not visible.
  always_comb begin
    rd_reg_c = '0;
    unique case (reg_addr_c)
      A_DFH:      rd_reg_c = DFH_VAL;
      A_ID_L:     rd_reg_c = AFU_ID[63:0];
      A_ID_H:     rd_reg_c = AFU_ID[127:64];
      A_SCRATCH:  rd_reg_c = scratch_q;
      A_SRC_ADDR: rd_reg_c = src_q;
      A_DST_ADDR: rd_reg_c = dst_q;
      A_LENGTH:   rd_reg_c = {{(DATA_W-CNT_W){1'b0}}, len_q};
      A_STATUS:   rd_reg_c = {done_cnt_q, 29'b0, start_err_q, done_sticky_q, stat_busy};
      A_CYCLES:   rd_reg_c = cycles_q;
      default:    rd_reg_c = '0;
    endcase
    rd_data_c = rd_reg_c;
    if (is4_c) begin
      if (mmio_addr[0]) rd_data_c = {{HALF_W{1'b0}}, rd_reg_c[DATA_W-1:HALF_W]};
      else              rd_data_c = {{HALF_W{1'b0}}, rd_reg_c[HALF_W-1:0]};
    end
  end

  // CONTROL bits live in the low half; a 4 B write to the high half carries none.
  always_comb begin
    start_req_c = mmio_wr_valid & (reg_addr_c == A_CONTROL) & ~hi_c & mmio_wdata[0];
    clear_req_c = mmio_wr_valid & (reg_addr_c == A_CONTROL) & ~hi_c & mmio_wdata[1];
  end

  // Next-state logic for the register file, status and response path.
  always_comb begin
    scratch_d     = scratch_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    start_d       = 1'b0;
    done_sticky_d = done_sticky_q;
    start_err_d   = start_err_q;
    done_cnt_d    = done_cnt_q;
    cycles_d      = cycles_q;
    cnt_base_c    = done_cnt_q;
    rsp_valid_d   = mmio_rd_valid;
    rsp_tid_d     = rsp_tid_q;
    rsp_data_d    = rsp_data_q;

    if (mmio_wr_valid) begin
      unique case (reg_addr_c)
        A_SCRATCH:  scratch_d = merge_w(scratch_q, mmio_wdata, is4_c, hi_c);
        A_SRC_ADDR: src_d     = merge_w(src_q, mmio_wdata, is4_c, hi_c);
        A_DST_ADDR: dst_d     = merge_w(dst_q, mmio_wdata, is4_c, hi_c);
        A_LENGTH:   if (!hi_c) len_d = mmio_wdata[CNT_W-1:0];
        default:    ;
      endcase
    end

    // Clear is applied before this cycle's done/busy/error updates.
    if (clear_req_c) begin
      done_sticky_d = 1'b0;
      start_err_d   = 1'b0;
      cnt_base_c    = '0;
    end

    if (start_req_c) begin
      if (stat_busy) start_err_d = 1'b1;
      else           start_d     = 1'b1;
    end

    done_cnt_d = cnt_base_c;
    if (stat_done) begin
      done_sticky_d = 1'b1;
      if (cnt_base_c != CNT_MAX) done_cnt_d = cnt_base_c + CNT_W'(1);
    end

    if (clear_req_c)    cycles_d = '0;
    else if (stat_busy) cycles_d = cycles_q + DATA_W'(1);

    if (mmio_rd_valid) begin
      rsp_tid_d  = mmio_tid;
      rsp_data_d = rd_data_c;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q     <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      start_q       <= 1'b0;
      done_sticky_q <= 1'b0;
      start_err_q   <= 1'b0;
      done_cnt_q    <= '0;
      cycles_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tid_q     <= '0;
      rsp_data_q    <= '0;
    end else begin
      scratch_q     <= scratch_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      len_q         <= len_d;
      start_q       <= start_d;
      done_sticky_q <= done_sticky_d;
      start_err_q   <= start_err_d;
      done_cnt_q    <= done_cnt_d;
      cycles_q      <= cycles_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tid_q     <= rsp_tid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_tid       = rsp_tid_q;
  assign rsp_data      = rsp_data_q;
  assign ctrl_start    = start_q;
  assign ctrl_src_addr = src_q;
  assign ctrl_dst_addr = dst_q;
  assign ctrl_len      = len_q;

endmodule

// File: tb/tb_ccip_mmio_csr.sv
// Testbench for ccip_mmio_csr: directed scenarios plus randomized traffic,
// responses checked by a scoreboard against a register-map reference model.
module tb_ccip_mmio_csr;

  localparam logic [127:0] AFU = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
  localparam logic [63:0]  DFH = 64'h1000_0100_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic        mmio_wr_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [1:0]  mmio_len = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wdata = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        ctrl_start;
  logic [63:0] ctrl_src_addr;
  logic [63:0] ctrl_dst_addr;
  logic [31:0] ctrl_len;
  logic        stat_busy = 1'b0;
  logic        stat_done = 1'b0;

  ccip_mmio_csr #(.AFU_ID(AFU)) dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_len(mmio_len), .mmio_tid(mmio_tid),
    .mmio_wdata(mmio_wdata),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .ctrl_start(ctrl_start), .ctrl_src_addr(ctrl_src_addr),
    .ctrl_dst_addr(ctrl_dst_addr), .ctrl_len(ctrl_len),
    .stat_busy(stat_busy), .stat_done(stat_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state: the architectural register map.
  logic [63:0] m_scratch, m_src, m_dst, m_cycles;
  logic [31:0] m_len, m_cnt;
  bit          m_sticky, m_err, m_start;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_scratch = '0; m_src = '0; m_dst = '0; m_cycles = '0;
    m_len = '0; m_cnt = '0; m_sticky = 0; m_err = 0; m_start = 0;
  endtask

  function automatic logic [63:0] put(input logic [63:0] old_v, input logic [63:0] wd,
                                      input logic [15:0] a, input logic [1:0] l);
    if (l != 2'd0) return wd;
    if (a[0]) return (old_v & 64'h0000_0000_FFFF_FFFF) | ({32'h0, wd[31:0]} << 32);
    return (old_v & 64'hFFFF_FFFF_0000_0000) | {32'h0, wd[31:0]};
  endfunction

  function automatic logic [63:0] model_read(input logic [15:0] a, input logic [1:0] l,
                                             input bit busy);
    logic [63:0] r;
    logic [15:0] base;
    base = a & 16'hFFFE;
    case (base)
      16'h0000: r = DFH;
      16'h0002: r = AFU[63:0];
      16'h0004: r = AFU[127:64];
      16'h0020: r = m_scratch;
      16'h0022: r = m_src;
      16'h0024: r = m_dst;
      16'h0026: r = {32'h0, m_len};
      16'h002A: r = ({32'h0, m_cnt} << 32) | (64'(m_err) << 2) | (64'(m_sticky) << 1) | 64'(busy);
      16'h002C: r = m_cycles;
      default:  r = '0;
    endcase
    if (l == 2'd0) r = a[0] ? (r >> 32) : (r & 64'h0000_0000_FFFF_FFFF);
    return r;
  endfunction

  // One bus cycle: drive, predict, clock, then check the job-control outputs.
  task automatic cyc(input bit rd, input bit wr, input logic [15:0] a, input logic [1:0] l,
                     input logic [8:0] t, input logic [63:0] wd, input bit busy, input bit done);
    logic [63:0] exp_rd, tmp;
    logic [15:0] base;
    bit st, clr;
    mmio_rd_valid = rd; mmio_wr_valid = wr; mmio_addr = a; mmio_len = l;
    mmio_tid = t; mmio_wdata = wd; stat_busy = busy; stat_done = done;
    exp_rd = model_read(a, l, busy);
    base = a & 16'hFFFE;
    st = 0; clr = 0;
    if (wr) begin
      case (base)
        16'h0020: m_scratch = put(m_scratch, wd, a, l);
        16'h0022: m_src = put(m_src, wd, a, l);
        16'h0024: m_dst = put(m_dst, wd, a, l);
        16'h0026: begin tmp = put({32'h0, m_len}, wd, a, l); m_len = tmp[31:0]; end
        16'h0028: begin tmp = put(64'h0, wd, a, l); st = tmp[0]; clr = tmp[1]; end
        default: ;
      endcase
    end
    if (clr) begin m_sticky = 0; m_err = 0; m_cnt = 0; end
    m_start = st && !busy;
    if (st && busy) m_err = 1;
    if (done) begin
      m_sticky = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    if (clr) m_cycles = 0;
    else if (busy) m_cycles = m_cycles + 1;
    @(posedge clk);
    if (rd) exp_q.push_back('{tid: t, data: exp_rd});
    #1;
    check("ctrl_start", 64'(ctrl_start), 64'(m_start));
    check("ctrl_src_addr", ctrl_src_addr, m_src);
    check("ctrl_dst_addr", ctrl_dst_addr, m_dst);
    check("ctrl_len", 64'(ctrl_len), 64'(m_len));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 2'd1, 9'h0, 64'h0, 0, 0);
  endtask

  task automatic rd8(input logic [15:0] a, input logic [8:0] t);
    cyc(1, 0, a, 2'd1, t, 64'h0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    mmio_rd_valid = 0; mmio_wr_valid = 0; stat_busy = 0; stat_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every presented response must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 tid=%h expected no response", rsp_tid);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_tid", 64'(rsp_tid), 64'(e.tid));
          check("rsp_data", rsp_data, e.data);
        end
      end else if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        n_total++;
        $display("FAIL rsp_missing: got rsp_valid=0 expected response tid=%h", e.tid);
      end
    end
  end

  logic [15:0] addr_tbl [14];

  initial begin
    addr_tbl = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0020, 16'h0022,
                 16'h0024, 16'h0026, 16'h0028, 16'h002A, 16'h002C, 16'h002E, 16'h0140};
    do_reset();
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_tid", 64'(rsp_tid), 64'h0);
    check("reset_rsp_data", rsp_data, 64'h0);
    check("reset_ctrl_start", 64'(ctrl_start), 64'h0);
    check("reset_ctrl_len", 64'(ctrl_len), 64'h0);
    @(posedge clk); #1;

    // Identity registers, tids echoed.
    rd8(16'h0000, 9'd1); rd8(16'h0002, 9'd2); rd8(16'h0004, 9'd3);
    idle(1);

    // Full write then high-half 4 B write of SCRATCH.
    cyc(0, 1, 16'h0020, 2'd1, 0, 64'hDEADBEEF_CAFEF00D, 0, 0);
    cyc(0, 1, 16'h0021, 2'd0, 0, 64'h0000_0000_1234_5678, 0, 0);
    rd8(16'h0020, 9'd4);
    cyc(1, 0, 16'h0020, 2'd0, 9'd5, 0, 0, 0);
    cyc(1, 0, 16'h0021, 2'd0, 9'd6, 0, 0, 0);
    idle(1);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) rd8(16'h0020 + 16'(2 * i), 9'(10 + i));
    idle(1);

    // Start idle -> pulse; start busy -> error sticky.
    cyc(0, 1, 16'h0028, 2'd1, 0, 64'h1, 0, 0);
    idle(2);
    cyc(0, 1, 16'h0028, 2'd1, 0, 64'h1, 1, 0);
    idle(1);
    rd8(16'h002A, 9'd20);
    idle(1);

    // Done counting, then clear coinciding with done.
    cyc(0, 1, 16'h0028, 2'd1, 0, 64'h2, 0, 0);
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 0, 2'd1, 0, 0, 0, 1); idle(1); end
    rd8(16'h002A, 9'd21);
    cyc(0, 1, 16'h0028, 2'd1, 0, 64'h2, 0, 1);
    rd8(16'h002A, 9'd22);
    cyc(1, 0, 16'h002B, 2'd0, 9'd23, 0, 0, 0);

    // Same-cycle read and write returns the old value.
    cyc(0, 1, 16'h0020, 2'd1, 0, 64'd5, 0, 0);
    cyc(1, 1, 16'h0020, 2'd1, 9'd30, 64'd9, 0, 0);
    rd8(16'h0020, 9'd31);

    // Busy cycle counting and clear priority.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 2'd1, 0, 0, 1, 0);
    cyc(1, 0, 16'h002C, 2'd1, 9'd32, 0, 0, 0);
    cyc(0, 1, 16'h0028, 2'd1, 0, 64'h2, 1, 0);
    rd8(16'h002C, 9'd33);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      logic [63:0] wd;
      bit rd, wr;
      a  = addr_tbl[$urandom_range(0, 13)] | 16'($urandom_range(0, 1));
      rd = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 2) == 0);
      wd = {$urandom, $urandom};
      if ((a & 16'hFFFE) == 16'h0028) wd = 64'($urandom_range(0, 2));
      cyc(rd, wr, a, 2'($urandom_range(0, 3)), 9'($urandom), wd,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
    end
    idle(2);

    // Reset with a response in flight: it must be dropped.
    rd8(16'h0002, 9'd40);
    do_reset();
    #1 check("post_reset_rsp_valid", 64'(rsp_valid), 64'h0);
    @(posedge clk); #1;
    rd8(16'h0020, 9'd41);
    rd8(16'h0004, 9'd42);
    idle(3);
    check("drain_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
